// File: rtl/rk_core_seq.sv
// rk_core_seq -- instruction sequencer for the RK16 multicycle core.
//
// Owns the program counter and the one-hot stage ring of a single-clock
// multicycle core. Each instruction walks NSTAGE stages. The stage at
// MEM_STAGE can be held on a data-memory handshake. The last stage commits
// the next PC, which is one of: sequential, jump, interrupt entry, or
// return-from-interrupt.
//
// Optional feature macro: RK_SEQ_NESTED_INTR_EN
//   undefined (default) : interrupts are masked while servicing one, until
//                         an iret commits.
//   defined             : no mask; every commit with intr high enters the
//                         handler and overwrites epc.
//
// Ports
//   clk         in   1       core clock, all state on rising edge
//   rst_n       in   1       synchronous reset, active-low
//   mem_req     in   1       current instruction accesses data mem in MEM_STAGE
//   mem_ack     in   1       data mem access completes this cycle
//   jmp_take    in   1       take jmp_target at commit
//   jmp_target  in   XLEN    branch/jump destination
//   intr        in   1       level interrupt request, sampled at commit only
//   iret        in   1       current instruction is return-from-interrupt
//   stage       out  NSTAGE  one-hot current stage
//   stage_en    out  NSTAGE  one-hot execute enable, zero while waiting/in reset
//   pc          out  XLEN    address of current instruction
//   stall       out  1       high while the memory stage is waiting
//   intr_ack    out  1       pulse on the commit cycle that takes the interrupt
//   epc         out  XLEN    saved return PC
module rk_core_seq #(
  parameter int XLEN      = 16,
  parameter int NSTAGE    = 4,
  parameter int MEM_STAGE = 2,
  parameter int RESET_PC  = 0,
  parameter int INTR_VEC  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_req,
  input  logic              mem_ack,
  input  logic              jmp_take,
  input  logic [XLEN-1:0]   jmp_target,
  input  logic              intr,
  input  logic              iret,
  output logic [NSTAGE-1:0] stage,
  output logic [NSTAGE-1:0] stage_en,
  output logic [XLEN-1:0]   pc,
  output logic              stall,
  output logic              intr_ack,
  output logic [XLEN-1:0]   epc
);

  typedef enum logic {S_RUN, S_WAIT} state_t;

  state_t            state;
  state_t            state_nxt;
  logic              in_isr;
  logic              in_isr_nxt;
  logic              blocked;
  logic              exec;
  logic              commit;
  logic              intr_take;
  logic [XLEN-1:0]   pc_seq;
  logic [XLEN-1:0]   pc_nxt;
  logic [XLEN-1:0]   epc_nxt;

  // PC increment; the carry out of the top bit is dropped so the PC wraps.
  function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] a);
    return a + {{(XLEN-1){1'b0}}, 1'b1};
  endfunction

  always_comb begin
    state_nxt  = state;
    stage_en   = '0;
    stall      = 1'b0;
    intr_ack   = 1'b0;
    blocked    = 1'b0;
    exec       = 1'b0;
    commit     = 1'b0;
    intr_take  = 1'b0;
    pc_nxt     = pc;
    epc_nxt    = epc;
    in_isr_nxt = in_isr;
    pc_seq     = jmp_take ? jmp_target : pc_inc(pc);

    // The memory stage does not execute until the ack arrives. This also
    // covers the first cycle of the wait, so a memory stage that is also the
    // commit stage can never commit early.
    case (state)
      S_RUN:   blocked = stage[MEM_STAGE] && mem_req && !mem_ack;
      S_WAIT:  blocked = !mem_ack;
      default: blocked = 1'b0;
    endcase

    exec      = rst_n && !blocked;
    stall     = rst_n && blocked;
    state_nxt = blocked ? S_WAIT : S_RUN;
    if (exec) stage_en = stage;
    commit = exec && stage[NSTAGE-1];

`ifdef RK_SEQ_NESTED_INTR_EN
    intr_take = commit && !iret && intr;
`else
    intr_take = commit && !iret && intr && !in_isr;
`endif
    intr_ack = intr_take;

    if (commit) begin
      if (iret) begin
        pc_nxt     = epc;
        in_isr_nxt = 1'b0;
      end else if (intr_take) begin
        // The return address is the PC this instruction would have
        // committed, so a jump that coincides with an interrupt is not lost.
        epc_nxt    = pc_seq;
        pc_nxt     = XLEN'(INTR_VEC);
        in_isr_nxt = 1'b1;
      end else begin
        pc_nxt = pc_seq;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_RUN;
    else        state <= state_nxt;
  end

  // Stage ring and architectural PC state. A reset abandons any
  // in-flight instruction or wait without committing it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage  <= {{(NSTAGE-1){1'b0}}, 1'b1};
      pc     <= XLEN'(RESET_PC);
      epc    <= '0;
      in_isr <= 1'b0;
    end else begin
      if (exec) stage <= {stage[NSTAGE-2:0], stage[NSTAGE-1]};
      pc     <= pc_nxt;
      epc    <= epc_nxt;
      in_isr <= in_isr_nxt;
    end
  end

endmodule

// File: tb/tb_rk_core_seq.sv
// Testbench for rk_core_seq (default parameters). An instruction-level
// model tracks the stage index, PC, epc and interrupt mask, and the outputs
// are compared with it every cycle. Literal checks pin the model to the
// expected behaviour of the directed scenarios.
module tb_rk_core_seq;
  localparam int XLEN = 16;
  localparam int NSTAGE = 4;
  localparam int MEM_STAGE = 2;
  localparam int RESET_PC = 0;
  localparam int INTR_VEC = 1;
`ifdef RK_SEQ_NESTED_INTR_EN
  localparam bit NESTED = 1'b1;
`else
  localparam bit NESTED = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              mem_req;
  logic              mem_ack;
  logic              jmp_take;
  logic [XLEN-1:0]   jmp_target;
  logic              intr;
  logic              iret;
  logic [NSTAGE-1:0] stage;
  logic [NSTAGE-1:0] stage_en;
  logic [XLEN-1:0]   pc;
  logic              stall;
  logic              intr_ack;
  logic [XLEN-1:0]   epc;

  rk_core_seq #(
    .XLEN(XLEN), .NSTAGE(NSTAGE), .MEM_STAGE(MEM_STAGE),
    .RESET_PC(RESET_PC), .INTR_VEC(INTR_VEC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_ack(mem_ack),
    .jmp_take(jmp_take), .jmp_target(jmp_target), .intr(intr), .iret(iret),
    .stage(stage), .stage_en(stage_en), .pc(pc), .stall(stall),
    .intr_ack(intr_ack), .epc(epc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model state
  bit              m_valid = 1'b0;
  int              m_k;
  logic [XLEN-1:0] m_pc;
  logic [XLEN-1:0] m_epc;
  bit              m_isr;
  bit              m_wait;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: compare outputs with the model at the falling edge
  // (inputs are stable then), advance the model to what the next rising
  // edge must produce, then return just after that edge.
  task automatic step();
    bit              blocked, exec, commit, take;
    logic [XLEN-1:0] nxt;
    logic [NSTAGE-1:0] exp_stage;
    @(negedge clk);
    blocked   = (m_k == MEM_STAGE) && (mem_req || m_wait) && !mem_ack;
    exec      = rst_n && !blocked;
    commit    = exec && (m_k == NSTAGE-1);
    take      = commit && !iret && intr && (NESTED || !m_isr);
    exp_stage = NSTAGE'(1) << m_k;
    nxt       = jmp_take ? jmp_target : XLEN'(m_pc + 1);
    if (m_valid) begin
      check("stage", 32'(stage), 32'(exp_stage));
      check("stage_en", 32'(stage_en), exec ? 32'(exp_stage) : 32'd0);
      check("stall", 32'(stall), 32'(rst_n && blocked));
      check("pc", 32'(pc), 32'(m_pc));
      check("epc", 32'(epc), 32'(m_epc));
      check("intr_ack", 32'(intr_ack), 32'(take));
    end
    if (!rst_n) begin
      m_valid = 1'b1;
      m_k = 0; m_pc = XLEN'(RESET_PC); m_epc = '0; m_isr = 1'b0; m_wait = 1'b0;
    end else if (blocked) begin
      m_wait = 1'b1;
    end else begin
      m_wait = 1'b0;
      if (commit) begin
        if (iret) begin
          m_pc = m_epc; m_isr = 1'b0;
        end else if (take) begin
          m_epc = nxt; m_pc = XLEN'(INTR_VEC); m_isr = 1'b1;
        end else begin
          m_pc = nxt;
        end
      end
      m_k = (m_k + 1) % NSTAGE;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst_n = 1'b0; mem_req = 1'b0; mem_ack = 1'b0; jmp_take = 1'b0;
    jmp_target = '0; intr = 1'b0; iret = 1'b0;

    // Reset
    steps(2);
    check("rst_stage", 32'(stage), 32'd1);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_stage_en", 32'(stage_en), 32'd0);
    rst_n = 1'b1;

    // 1: free-running sequence
    steps(4);
    check("seq_pc1", 32'(pc), 32'd1);
    check("seq_stage", 32'(stage), 32'd1);
    steps(4);
    check("seq_pc2", 32'(pc), 32'd2);

    // 2: memory wait of three cycles at stage 4
    mem_req = 1'b1;
    steps(3);
    check("wait_stage", 32'(stage), 32'd4);
    step();
    check("wait_stall", 32'(stall), 32'd1);
    check("wait_en", 32'(stage_en), 32'd0);
    step();
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0; mem_req = 1'b0;
    step();
    check("wait_pc", 32'(pc), 32'd3);
    check("wait_end_stage", 32'(stage), 32'd1);

    // 3: jump, then sequential wrap at the top of the address space
    steps(3);
    jmp_take = 1'b1; jmp_target = 16'h0040;
    step();
    jmp_take = 1'b0;
    check("jmp_pc", 32'(pc), 32'h0040);
    steps(3);
    jmp_take = 1'b1; jmp_target = 16'hFFFF;
    step();
    jmp_take = 1'b0;
    steps(4);
    check("wrap_pc", 32'(pc), 32'h0000);

    // 4: interrupt coinciding with a jump; intr held afterwards
    steps(3);
    intr = 1'b1; jmp_take = 1'b1; jmp_target = 16'h0020;
    #1;
    check("int_ack_pulse", 32'(intr_ack), 32'd1);
    step();
    jmp_take = 1'b0;
    check("int_pc", 32'(pc), 32'd1);
    check("int_epc", 32'(epc), 32'h0020);
    steps(4);
`ifdef RK_SEQ_NESTED_INTR_EN
    check("int_held_pc", 32'(pc), 32'd1);
`else
    check("int_held_pc", 32'(pc), 32'd2);
`endif

    // 5: iret wins over a pending interrupt; interrupt taken next commit
    steps(3);
    iret = 1'b1;
    #1;
    check("iret_ack", 32'(intr_ack), 32'd0);
    step();
    iret = 1'b0;
`ifdef RK_SEQ_NESTED_INTR_EN
    check("iret_pc", 32'(pc), 32'd2);
`else
    check("iret_pc", 32'(pc), 32'h0020);
`endif
    steps(4);
    check("reint_pc", 32'(pc), 32'd1);
    intr = 1'b0;

    // 6: reset while waiting on memory
    mem_req = 1'b1;
    steps(4);
    check("pre_rst_stall", 32'(stall), 32'd1);
    rst_n = 1'b0;
    step();
    check("rst_wait_stage", 32'(stage), 32'd1);
    check("rst_wait_pc", 32'(pc), 32'd0);
    check("rst_wait_epc", 32'(epc), 32'd0);
    check("rst_wait_stall", 32'(stall), 32'd0);
    check("rst_wait_en", 32'(stage_en), 32'd0);
    mem_req = 1'b0;
    step();
    rst_n = 1'b1;

    // Same-cycle ack and acks outside the memory stage never stall
    mem_req = 1'b1; mem_ack = 1'b1;
    steps(4);
    check("ack_same_pc", 32'(pc), 32'd1);
    mem_req = 1'b0; mem_ack = 1'b0;
    steps(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
